fcmp_arbiter: RTL and testbench
===============================

Name: fcmp_arbiter

Overview:
- Shares one pipelined FP compare unit (flt/fle/feq datapath: single-cycle registered result, 1-bit answer in bit 0 of a 32-bit word) between two VLIW issue lanes.
- Round-robin arbitration of per-lane valid/ready requests; drives the compare unit's operand/op inputs.
- Tracks in-flight ownership and tags through the unit's latency; returns results into per-lane response FIFOs.
- Credit-based issue guarantees a FIFO never overflows under response backpressure.

Parameters:
CMP_LAT, 1, cycles from cmp_issue to cmp_z valid (compare unit register depth, >=1)
TAG_W, 6, width of destination tag carried with each request
RES_DEPTH, 2, entries per lane response FIFO (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-low reset
req_valid  input  2  request valid, bit i = lane i
req_ready  output  2  request accepted this cycle, bit i = lane i
req_op  input  4  lane i op at [2i+1:2i]: 00 lt, 01 le, 10 eq, 11 reserved (passed through)
req_x  input  64  lane i operand x at [32i+31:32i]
req_y  input  64  lane i operand y at [32i+31:32i]
req_tag  input  2*TAG_W  lane i tag at [TAG_W*i +: TAG_W]
cmp_issue  output  1  operands on cmp_* are a real operation this cycle
cmp_op  output  2  op to compare unit
cmp_x  output  32  operand x to compare unit
cmp_y  output  32  operand y to compare unit
cmp_z  input  32  compare result, valid CMP_LAT cycles after issue; only bit 0 used
rsp_valid  output  2  response valid per lane
rsp_ready  input  2  response consumed per lane
rsp_data  output  64  lane i result at [32i+31:32i] = {31'b0, result bit}
rsp_tag  output  2*TAG_W  lane i tag

Behaviour:
- Reset (rst=0 at clk edge): in-flight pipeline cleared, both FIFOs empty, last_grant=1 (lane 0 wins first). Outputs after reset: req_ready=0, cmp_issue=0, rsp_valid=0, rsp_data=0, rsp_tag=0.
- Reset mid-operation discards all in-flight and buffered results. cmp_z returning after reset is ignored.
- Credit per lane: cnt_i = FIFO occupancy + in-flight ops owned by lane i; registered.
- Lane eligible iff req_valid[i] and cnt_i < RES_DEPTH.
- A pop frees credit only from the next cycle. No combinational path from rsp_ready to req_ready.
- Arbitration:
  - One eligible lane: it is granted.
  - Both eligible: grant lane != last_grant.
  - last_grant updates only on a grant.
- req_ready = one-hot grant; at most one bit set; depends on req_valid (requesters must not wait for ready before asserting valid).
- Handshake: a request transfers when req_valid[i] & req_ready[i]. Requesters hold op/x/y/tag stable while valid and not ready.
- Issue datapath:
  - cmp_x/cmp_y/cmp_op are combinationally muxed from the granted lane; cmp_issue = |req_ready.
  - With no grant: cmp_issue=0 and cmp_* carry lane 0 inputs (don't care).
- Tracking: CMP_LAT-deep shift register of {valid, lane, tag} advances every cycle. The entry reaching the end in the same cycle cmp_z is valid pushes {cmp_z[0], tag} into that lane's FIFO.
- Throughput: one issue per cycle total. Back-to-back issues from the same lane are allowed while credits remain.
- FIFO: rsp_valid = not empty; head shown on rsp_data/rsp_tag. Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Results per lane leave in issue order.
  - Overflow is impossible by credit; an assertion checks it.
- Op 11 is forwarded unchanged; the result is whatever the unit returns.

Test Plan:
- Lane 0: x=0x40000000 (2.0), y=0x40400000 (3.0), op=00, tag=5, rsp_ready=1 -> req_ready=01 same cycle, cmp_issue=1; after CMP_LAT+1 edges rsp_valid[0]=1, rsp_data0=0x00000001, rsp_tag0=5.
- Both lanes valid in the first cycle after reset (lane 1: x=0xC0000000, y=0xBF800000, op=00, tag=9) -> lane 0 granted cycle 0, lane 1 cycle 1 (result 1, tag 9). With both held valid continuously, grants alternate 0,1,0,1.
- RES_DEPTH=2, rsp_ready[0]=0, lane 0 streams 3 requests (tags 1,2,3) -> tags 1,2 accepted, req_ready[0]=0 thereafter. Raising rsp_ready[0] for one cycle pops tag 1; tag 3 is accepted the following cycle; order 1,2,3 preserved.
- Lane 0 stalled on credits while lane 1 valid -> lane 1 granted every cycle despite round-robin pointer.
- Assert rst=0 one cycle after two issues -> no rsp_valid ever appears for them; FIFOs empty; the next request completes normally with correct tag.
- Equal operands 0x3F800000, op=00 -> data 0; op=01 -> 1; op=10 -> 1; same tag returned each time.

Source files
------------

// File: rtl/fcmp_arbiter.sv
// fcmp_arbiter: shares one pipelined FP compare unit between two issue lanes with a
// round-robin grant, in-flight tag tracking and credit-protected response FIFOs.
module fcmp_arbiter #(
    parameter int CMP_LAT   = 1,
    parameter int TAG_W     = 6,
    parameter int RES_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op,
    input  logic [63:0]          req_x,
    input  logic [63:0]          req_y,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic                 cmp_issue,
    output logic [1:0]           cmp_op,
    output logic [31:0]          cmp_x,
    output logic [31:0]          cmp_y,
    input  logic [31:0]          cmp_z,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [63:0]          rsp_data,
    output logic [2*TAG_W-1:0]   rsp_tag
);

    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RES_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RES_DEPTH - 1);

    typedef struct packed {
        logic             valid;
        logic             lane;
        logic [TAG_W-1:0] tag;
    } track_t;

    logic [CNT_W-1:0] credit_cnt [2];
    logic             last_grant;
    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic [TAG_W-1:0] issue_tag;
    track_t           issue_entry;
    track_t           pipe [CMP_LAT];
    track_t           pipe_out;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             unused_cmp_hi;

    // Credits count buffered plus in-flight results, so a grant never outruns FIFO space.
    assign eligible[0] = req_valid[0] && (credit_cnt[0] < DEPTH_C);
    assign eligible[1] = req_valid[1] && (credit_cnt[1] < DEPTH_C);

    always_comb begin
        // NOTE: default assignment first so every path drives grant and no latch is inferred
        grant = 2'b00;
        unique case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = grant;
    assign cmp_issue = |grant;
    assign cmp_op    = grant[1] ? req_op[3:2]   : req_op[1:0];
    assign cmp_x     = grant[1] ? req_x[63:32]  : req_x[31:0];
    assign cmp_y     = grant[1] ? req_y[63:32]  : req_y[31:0];
    assign issue_tag = grant[1] ? req_tag[TAG_W +: TAG_W] : req_tag[0 +: TAG_W];

    assign issue_entry   = {cmp_issue, grant[1], issue_tag};
    assign unused_cmp_hi = ^cmp_z[31:1];

    // NOTE: sequential state uses non-blocking assignments so all registers update together
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant    <= 1'b1;
            credit_cnt[0] <= '0;
            credit_cnt[1] <= '0;
        end else begin
            if (|grant) begin
                last_grant <= grant[1];
            end
            for (int i = 0; i < 2; i++) begin
                credit_cnt[i] <= credit_cnt[i] + CNT_W'(grant[i]) - CNT_W'(pop[i]);
            end
        end
    end

    // Ownership pipeline mirrors the compare unit depth; its tail lines up with cmp_z.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < CMP_LAT; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            pipe[0] <= issue_entry;
            for (int s = 1; s < CMP_LAT; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    assign pipe_out = pipe[CMP_LAT-1];
    assign push[0]  = pipe_out.valid && !pipe_out.lane;
    assign push[1]  = pipe_out.valid &&  pipe_out.lane;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [TAG_W:0]   mem [RES_DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
        logic             full;

        assign rsp_valid[l] = (count != '0);
        assign full         = (count == DEPTH_C);
        assign pop[l]       = rsp_valid[l] && rsp_ready[l];

        // Outputs are gated by occupancy so an empty FIFO always presents zeros.
        assign rsp_data[32*l +: 32]      = rsp_valid[l] ? {31'b0, mem[rd_ptr][TAG_W]} : 32'b0;
        assign rsp_tag[TAG_W*l +: TAG_W] = rsp_valid[l] ? mem[rd_ptr][TAG_W-1:0] : '0;

        // NOTE: storage is not reset; count alone decides which entries are live
        always_ff @(posedge clk) begin
            if (push[l]) begin
                mem[wr_ptr] <= {cmp_z[0], pipe_out.tag};
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[l]) begin
                    wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                end
                if (pop[l]) begin
                    rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                end
                count <= count + CNT_W'(push[l]) - CNT_W'(pop[l]);
            end
        end

        overflow_check: assert property (@(posedge clk) disable iff (!rst)
            !(push[l] && full && !pop[l]));
    end

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Randomized bench for fcmp_arbiter: a transaction-level model of grants, credits
// and per-lane result queues predicts every handshake and response.
module tb_fcmp_arbiter;

    localparam int CMP_LAT   = 1;
    localparam int TAG_W     = 6;
    localparam int RES_DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [3:0]         req_op;
    logic [63:0]        req_x;
    logic [63:0]        req_y;
    logic [2*TAG_W-1:0] req_tag;
    logic               cmp_issue;
    logic [1:0]         cmp_op;
    logic [31:0]        cmp_x;
    logic [31:0]        cmp_y;
    logic [31:0]        cmp_z;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [63:0]        rsp_data;
    logic [2*TAG_W-1:0] rsp_tag;

    always #5 clk = ~clk;

    fcmp_arbiter #(.CMP_LAT(CMP_LAT), .TAG_W(TAG_W), .RES_DEPTH(RES_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
        .cmp_issue(cmp_issue), .cmp_op(cmp_op), .cmp_x(cmp_x), .cmp_y(cmp_y),
        .cmp_z(cmp_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag)
    );

    typedef struct { logic [1:0] op; logic [31:0] x; logic [31:0] y; logic [TAG_W-1:0] tag; } req_t;
    typedef struct { logic res; logic [TAG_W-1:0] tag; int cyc; } exp_t;
    typedef struct { int lane; logic [TAG_W-1:0] tag; logic [31:0] data; } pop_t;

    req_t rq [2][$];
    exp_t mq [2][$];
    pop_t pop_log [$];
    int   grant_log [$];
    logic last_grant = 1'b1;
    logic [1:0] rr;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // IEEE-754 single compare for non-NaN operands; +0 and -0 compare equal.
    function automatic logic fp_cmp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic eq, lt;
        eq = (a == b) || (a[30:0] == 31'd0 && b[30:0] == 31'd0);
        if (eq)                 lt = 1'b0;
        else if (a[31] != b[31]) lt = a[31];
        else if (!a[31])        lt = a[30:0] < b[30:0];
        else                    lt = a[30:0] > b[30:0];
        case (op)
            2'b00:   return lt;
            2'b01:   return lt || eq;
            2'b10:   return eq;
            default: return a[0] ^ b[0];
        endcase
    endfunction

    // Compare unit stand-in: upper result bits are junk that must be ignored.
    logic [31:0] cmp_pipe [CMP_LAT];
    always @(posedge clk) begin
        cmp_pipe[0] <= ($urandom() & 32'hFFFF_FFFE) | 32'(fp_cmp(cmp_op, cmp_x, cmp_y));
        for (int i = 1; i < CMP_LAT; i++) cmp_pipe[i] <= cmp_pipe[i-1];
    end
    assign cmp_z = cmp_pipe[CMP_LAT-1];

    task automatic push_req(input int lane, input logic [1:0] op, input logic [31:0] x,
                            input logic [31:0] y, input logic [TAG_W-1:0] tag);
        rq[lane].push_back('{op: op, x: x, y: y, tag: tag});
    endtask

    // One clock: drive, check outputs against the model, advance the model across the edge.
    task automatic cycle();
        req_t h [2];
        logic [1:0] elig, eg, exp_v;
        int gl;
        for (int l = 0; l < 2; l++) begin
            h[l] = '{op: 2'b00, x: 32'h0, y: 32'h0, tag: '0};
            if (rq[l].size() > 0) h[l] = rq[l][0];
            req_valid[l] = (rq[l].size() > 0);
        end
        req_op    = {h[1].op, h[0].op};
        req_x     = {h[1].x, h[0].x};
        req_y     = {h[1].y, h[0].y};
        req_tag   = {h[1].tag, h[0].tag};
        rsp_ready = rr;
        #1;
        for (int l = 0; l < 2; l++) elig[l] = req_valid[l] && (mq[l].size() < RES_DEPTH);
        eg = (elig == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : elig;
        gl = eg[1] ? 1 : 0;
        check("req_ready", 64'(req_ready), 64'(eg));
        check("cmp_issue", 64'(cmp_issue), 64'(|eg));
        if (|eg) begin
            check("cmp_x", 64'(cmp_x), 64'(h[gl].x));
            check("cmp_y", 64'(cmp_y), 64'(h[gl].y));
            check("cmp_op", 64'(cmp_op), 64'(h[gl].op));
        end
        for (int l = 0; l < 2; l++) begin
            exp_v[l] = (mq[l].size() > 0) && (mq[l][0].cyc + CMP_LAT + 1 <= cyc);
            check($sformatf("rsp_valid%0d", l), 64'(rsp_valid[l]), 64'(exp_v[l]));
            if (exp_v[l]) begin
                check($sformatf("rsp_data%0d", l), 64'(rsp_data[32*l +: 32]), 64'({31'b0, mq[l][0].res}));
                check($sformatf("rsp_tag%0d", l), 64'(rsp_tag[TAG_W*l +: TAG_W]), 64'(mq[l][0].tag));
            end
            if (rsp_valid[l] && rr[l])
                pop_log.push_back('{lane: l, tag: rsp_tag[TAG_W*l +: TAG_W], data: rsp_data[32*l +: 32]});
        end
        grant_log.push_back(req_ready[1] ? 1 : (req_ready[0] ? 0 : -1));
        if (!rst) begin
            mq[0].delete();
            mq[1].delete();
            last_grant = 1'b1;
        end else begin
            for (int l = 0; l < 2; l++)
                if (exp_v[l] && rr[l]) void'(mq[l].pop_front());
            for (int l = 0; l < 2; l++)
                if (eg[l]) mq[l].push_back('{res: fp_cmp(h[l].op, h[l].x, h[l].y), tag: h[l].tag, cyc: cyc});
            if (|eg) last_grant = eg[1];
        end
        for (int l = 0; l < 2; l++)
            if (eg[l]) void'(rq[l].pop_front());
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain();
        int budget = 200;
        rr = 2'b11;
        while (budget > 0 && (rq[0].size() + rq[1].size() + mq[0].size() + mq[1].size()) > 0) begin
            cycle();
            budget--;
        end
        check("drain_left", 64'(rq[0].size() + rq[1].size() + mq[0].size() + mq[1].size()), 64'd0);
        run(2);
    endtask

    task automatic reset_cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    function automatic int glog(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -2;
    endfunction

    function automatic logic [TAG_W-1:0] ptag(input int i);
        return (i < pop_log.size()) ? pop_log[i].tag : 'x;
    endfunction

    function automatic logic [31:0] pdata(input int i);
        return (i < pop_log.size()) ? pop_log[i].data : 'x;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom();
        v[30:23] = 8'($urandom_range(0, 254));
        if ($urandom_range(0, 7) == 0) v[30:0] = 31'd0;
        return v;
    endfunction

    initial begin
        logic [31:0] rx, ry;
        int n1;
        rst = 1'b0; rr = 2'b00; req_valid = 2'b00; req_op = '0;
        req_x = '0; req_y = '0; req_tag = '0; rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_cmp_issue", 64'(cmp_issue), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag), 64'd0);

        // Single lane 0 request: 2.0 < 3.0.
        rr = 2'b11; grant_log.delete(); pop_log.delete();
        push_req(0, 2'b00, 32'h4000_0000, 32'h4040_0000, 6'd5);
        run(4);
        check("t1_grant", 64'(glog(0)), 64'd0);
        check("t1_pops", 64'(pop_log.size()), 64'd1);
        check("t1_tag", 64'(ptag(0)), 64'd5);
        check("t1_data", 64'(pdata(0)), 64'd1);

        // Both lanes from the first cycle after reset; grants alternate.
        reset_cycle();
        grant_log.delete(); pop_log.delete();
        for (int i = 0; i < 4; i++) begin
            push_req(0, 2'b00, 32'h4000_0000, 32'h4040_0000, 6'd5);
            push_req(1, 2'b00, 32'hC000_0000, 32'hBF80_0000, 6'd9);
        end
        run(10);
        for (int i = 0; i < 6; i++) check($sformatf("t2_grant%0d", i), 64'(glog(i)), 64'(i % 2));
        drain();
        n1 = 0;
        foreach (pop_log[i])
            if (pop_log[i].lane == 1) begin
                check("t2_l1_tag", 64'(pop_log[i].tag), 64'd9);
                check("t2_l1_data", 64'(pop_log[i].data), 64'd1);
                n1++;
            end
        check("t2_l1_count", 64'(n1), 64'd4);

        // Lane 0 credit stall with its response port blocked.
        rr = 2'b10; grant_log.delete(); pop_log.delete();
        for (int t = 1; t <= 3; t++) push_req(0, 2'b01, 32'h3F80_0000, 32'h4000_0000, 6'(t));
        run(5);
        rr = 2'b11; cycle();
        rr = 2'b10; run(3);
        check("t3_g0", 64'(glog(0)), 64'd0);
        check("t3_g1", 64'(glog(1)), 64'd0);
        check("t3_g2", 64'(glog(2)), 64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_g5", 64'(glog(5)), 64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_g6", 64'(glog(6)), 64'd0);
        drain();
        for (int i = 0; i < 3; i++) check($sformatf("t3_order%0d", i), 64'(ptag(i)), 64'(i + 1));

        // Lane 0 out of credits: lane 1 takes every grant.
        rr = 2'b10;
        push_req(0, 2'b00, 32'h0, 32'h3F80_0000, 6'd20);
        push_req(0, 2'b00, 32'h0, 32'h3F80_0000, 6'd21);
        run(3);
        push_req(0, 2'b00, 32'h0, 32'h3F80_0000, 6'd22);
        for (int i = 0; i < 6; i++) push_req(1, 2'b10, 32'h1, 32'h1, 6'(40 + i));
        grant_log.delete();
        run(8);
        foreach (grant_log[i]) check("t4_no_lane0", 64'(grant_log[i] == 0), 64'd0);
        drain();

        // Reset right after two issues discards both results.
        rr = 2'b11; pop_log.delete();
        push_req(0, 2'b00, 32'h4000_0000, 32'h4040_0000, 6'd7);
        push_req(1, 2'b00, 32'h4000_0000, 32'h4040_0000, 6'd8);
        cycle();
        reset_cycle();
        run(4);
        check("t5_no_pops", 64'(pop_log.size()), 64'd0);
        push_req(0, 2'b01, 32'h4040_0000, 32'h4000_0000, 6'd33);
        drain();
        check("t5_pops", 64'(pop_log.size()), 64'd1);
        check("t5_tag", 64'(ptag(0)), 64'd33);
        check("t5_data", 64'(pdata(0)), 64'd0);

        // Equal operands under lt / le / eq.
        pop_log.delete();
        push_req(0, 2'b00, 32'h3F80_0000, 32'h3F80_0000, 6'd12);
        push_req(0, 2'b01, 32'h3F80_0000, 32'h3F80_0000, 6'd12);
        push_req(0, 2'b10, 32'h3F80_0000, 32'h3F80_0000, 6'd12);
        drain();
        check("t6_lt", 64'(pdata(0)), 64'd0);
        check("t6_le", 64'(pdata(1)), 64'd1);
        check("t6_eq", 64'(pdata(2)), 64'd1);
        for (int i = 0; i < 3; i++) check($sformatf("t6_tag%0d", i), 64'(ptag(i)), 64'd12);

        // Random traffic with response backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < 2; l++) begin
                if (rq[l].size() < 3 && $urandom_range(0, 2) == 0) begin
                    rx = rand_fp();
                    case ($urandom_range(0, 3))
                        0:       ry = rx;
                        1:       ry = rx ^ 32'h8000_0000;
                        default: ry = rand_fp();
                    endcase
                    push_req(l, 2'($urandom_range(0, 3)), rx, ry, 6'($urandom_range(0, 63)));
                end
                rr[l] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 499) != 0);
            cycle();
            rst = 1'b1;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
